serial_seq_detector: RTL

Downstream stage of the serial transmitter. It samples the transmitter's serial output `co` on clock edges where `cen` is high. It detects a parameterised bit pattern in that stream and counts the matches. In parallel it deserialises the stream back into bytes, so the bench can check the transmitted data end to end.

---
 rtl/serial_seq_detector.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_seq_detector.sv
// serial_seq_detector
// Samples the transmitter's serial output on cen strobes, detects PATTERN
// in the bit stream (counting matches, saturating) and reassembles the
// stream into bytes MSB first.
// Optional feature macro: SEQ_DET_OVERLAP_EN (overlapping matches allowed).
`timescale 1ns/1ps

module serial_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             sin,
    input  logic             clr_cnt,
    output logic             detect,
    output logic [CNT_W-1:0] det_count,
    output logic [7:0]       rx_byte,
    output logic             rx_valid
);

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    localparam logic [3:0] FULL     = 4'(PAT_LEN);
    localparam logic [3:0] FULL_M1  = 4'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [3:0]         fill_q, fill_d;
    logic [7:0]         sr_q, sr_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   det_count_q, det_count_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               rx_valid_q, rx_valid_d;

    logic [PAT_LEN-1:0] window;
    logic               match;

    // The window includes the bit being accepted; a match needs a full history
    assign window = {hist_q[PAT_LEN-2:0], sin};
    assign match  = cen && (fill_q >= FULL_M1) && (window == PATTERN);

    // Bit history, fill level and match FSM next-state
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        if (cen) begin
            hist_d = window;
            if (match && !OVERLAP) begin
                fill_d = 4'd0;
            end else if (fill_q != FULL) begin
                fill_d = fill_q + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    state_d = (fill_d == FULL) ? ARMED : FILL;
                end
                FILL: begin
                    if (match && !OVERLAP) begin
                        state_d = FILL;
                    end else if (fill_d == FULL) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (match && !OVERLAP) begin
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Match pulse and saturating counter; clear wins over an increment
    always_comb begin
        detect_d    = match;
        det_count_d = det_count_q;
        if (clr_cnt) begin
            det_count_d = '0;
        end else if (match && (det_count_q != {CNT_W{1'b1}})) begin
            det_count_d = det_count_q + 1'b1;
        end
    end

    // Byte assembler, MSB first, aligned to the first bit after reset
    always_comb begin
        sr_d       = sr_q;
        bitcnt_d   = bitcnt_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        if (cen) begin
            sr_d     = {sr_q[6:0], sin};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                rx_byte_d  = {sr_q[6:0], sin};
                rx_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hist_q      <= '0;
            fill_q      <= 4'd0;
            sr_q        <= 8'h00;
            bitcnt_q    <= 3'd0;
            detect_q    <= 1'b0;
            det_count_q <= '0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            detect_q    <= detect_d;
            det_count_q <= det_count_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign detect    = detect_q;
    assign det_count = det_count_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;

endmodule
